fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one `sync_fifo` write port among `NUM_REQ` independent producers. Each producer presents data with a valid/ready handshake. The arbiter grants at most one beat per cycle and holds a grant for bursts of up to `BURST_LEN` beats. It drives the FIFO's `wr_enable`/`data_in` and observes its `full` flag, so no beat is ever dropped.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
//
// Purpose: arbiter FSM state type and the width of the optional per-requester
//          beat counters.
// Contents:
//   arb_state_t : ARB_IDLE (arbitrating), ARB_BURST (grant held by owner)
//   STAT_W      : width of each beat counter field
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: find the first set bit of req, searching from last_owner+1
//          upwards and wrapping, so last_owner itself is checked last.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_owner in  IDX_W    most recent winner
//   found      out 1        at least one request is set
//   winner     out IDX_W    index of the chosen request (0 when none)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
//
// Purpose: lets NUM_REQ valid/ready producers share one sync_fifo write port.
//          A winner holds the grant for up to BURST_LEN beats; nothing is
//          accepted while the FIFO reports full.
// Ports:
//   clk            in  1              rising-edge clock
//   reset          in  1              asynchronous active-low reset
//   req_valid      in  NUM_REQ        per-requester beat available
//   req_data       in  NUM_REQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
//   req_ready      out NUM_REQ        one-hot accept (zero when none)
//   fifo_full      in  1              FIFO full flag
//   fifo_wr_enable out 1              FIFO write strobe
//   fifo_data_in   out WIDTH          FIFO write data (0 when not writing)
//   grant_id       out IDX_W          current winner (0 when not writing)
//   busy           out 1              burst grant held
//   beat_count     out NUM_REQ*16     per-requester saturating beat counters,
//                                     present only with FIFO_ARB_STATS_EN
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_enable,
  output logic [WIDTH-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]  beat_count
`endif
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BEATS_W = $clog2(BURST_LEN + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   last_owner;
  logic [IDX_W-1:0]   owner;
  logic [BEATS_W-1:0] beats;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_winner;
  logic [IDX_W-1:0]   sel;
  logic               xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .found      (pick_found),
    .winner     (pick_winner)
  );

  // Handshake is purely combinational so a fifo_full change is honoured in
  // the same cycle; outputs are forced low while reset is held.
  always_comb begin
    sel  = owner;
    xfer = 1'b0;
    if (state == ARB_IDLE) begin
      sel  = pick_winner;
      xfer = pick_found && !fifo_full;
    end else begin
      xfer = req_valid[owner] && !fifo_full;
    end
    if (!reset) begin
      xfer = 1'b0;
    end

    req_ready      = '0;
    fifo_wr_enable = xfer;
    fifo_data_in   = '0;
    grant_id       = '0;
    if (xfer) begin
      req_ready[sel] = 1'b1;
      fifo_data_in   = req_data[int'(sel)*WIDTH +: WIDTH];
      grant_id       = sel;
    end
  end

  assign busy = reset && (state == ARB_BURST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      last_owner <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      beats      <= '0;
    end else if (state == ARB_IDLE) begin
      if (xfer) begin
        last_owner <= sel;
        if (BURST_LEN > 1) begin
          owner <= sel;
          beats <= BEATS_W'(1);
          state <= ARB_BURST;
        end
      end
    end else begin
      // Owner going quiet ends the burst; the next cycle re-arbitrates.
      if (!req_valid[owner]) begin
        state <= ARB_IDLE;
        beats <= '0;
      end else if (xfer) begin
        if (int'(beats) + 1 == BURST_LEN) begin
          state <= ARB_IDLE;
          beats <= '0;
        end else begin
          beats <= beats + 1'b1;
        end
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [STAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (req_valid[i] && req_ready[i] && (cnt != {STAT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign beat_count[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule
